// File: rtl/ibex_multdiv_arbiter.sv
// Round-robin arbiter that shares one iterative ibex multdiv unit between NUM_REQ requesters.
// Define IBEX_MDARB_PERF_EN to add saturating busy/wait cycle counters (perf_busy_o, perf_wait_o).
module ibex_multdiv_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [NUM_REQ*2-1:0]    req_operator_i,
    input  logic [NUM_REQ*2-1:0]    req_signed_i,
    input  logic [NUM_REQ*32-1:0]   req_op_a_i,
    input  logic [NUM_REQ*32-1:0]   req_op_b_i,
    output logic [NUM_REQ-1:0]      rsp_valid_o,
    input  logic [NUM_REQ-1:0]      rsp_ready_i,
    output logic [31:0]             rsp_data_o,
    input  logic                    flush_i,
    output logic                    md_mult_en_o,
    output logic                    md_div_en_o,
    output logic                    md_mult_sel_o,
    output logic                    md_div_sel_o,
    output logic [1:0]              md_operator_o,
    output logic [1:0]              md_signed_mode_o,
    output logic [31:0]             md_op_a_o,
    output logic [31:0]             md_op_b_o,
    output logic                    md_ready_id_o,
    input  logic                    md_valid_i,
    input  logic [31:0]             md_result_i
`ifdef IBEX_MDARB_PERF_EN
    ,
    output logic [31:0]             perf_busy_o,
    output logic [31:0]             perf_wait_o
`endif
);

    localparam int IW = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e        state_q;
    logic [IW-1:0] rr_ptr_q;
    logic [IW-1:0] owner_q;
    logic [IW-1:0] rr_ptr_d;
    logic [31:0]   result_q;
    logic          discard_q;
    logic [1:0]    operator_q;
    logic [1:0]    signed_q;
    logic [31:0]   op_a_q;
    logic [31:0]   op_b_q;
    logic          mult_q;
    logic          div_q;
    logic          ready_id_q;

    logic [1:0]    req_op_arr  [NUM_REQ];
    logic [1:0]    req_sgn_arr [NUM_REQ];
    logic [31:0]   req_a_arr   [NUM_REQ];
    logic [31:0]   req_b_arr   [NUM_REQ];

    logic [IW-1:0] win_idx;
    logic          win_found;
    logic          accept;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= 32'(NUM_REQ)) begin
            sum = sum - 32'(NUM_REQ);
        end
        return IW'(sum);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_op_arr[gi]  = req_operator_i[gi*2 +: 2];
            assign req_sgn_arr[gi] = req_signed_i[gi*2 +: 2];
            assign req_a_arr[gi]   = req_op_a_i[gi*32 +: 32];
            assign req_b_arr[gi]   = req_op_b_i[gi*32 +: 32];
            assign req_ready_o[gi] = accept && !rst_i && (win_idx == IW'(gi));
            assign rsp_valid_o[gi] = (state_q == RESP) && (owner_q == IW'(gi));
        end
    endgenerate

    // Scan from the farthest offset down so the requester closest to rr_ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[wrap_add(rr_ptr_q, k)]) begin
                win_found = 1'b1;
                win_idx   = wrap_add(rr_ptr_q, k);
            end
        end
    end

    assign accept   = (state_q == IDLE) && win_found && !flush_i;
    assign rr_ptr_d = wrap_add(owner_q, 1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            result_q   <= '0;
            discard_q  <= 1'b0;
            operator_q <= '0;
            signed_q   <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            mult_q     <= 1'b0;
            div_q      <= 1'b0;
            ready_id_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        operator_q <= req_op_arr[win_idx];
                        signed_q   <= req_sgn_arr[win_idx];
                        op_a_q     <= req_a_arr[win_idx];
                        op_b_q     <= req_b_arr[win_idx];
                        owner_q    <= win_idx;
                        mult_q     <= ~req_op_arr[win_idx][1];
                        div_q      <= req_op_arr[win_idx][1];
                        ready_id_q <= 1'b1;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    // The multdiv freezes when disabled, so a flush only marks the result as dead.
                    if (md_valid_i) begin
                        mult_q     <= 1'b0;
                        div_q      <= 1'b0;
                        ready_id_q <= 1'b0;
                        discard_q  <= 1'b0;
                        if (discard_q || flush_i) begin
                            state_q  <= IDLE;
                            rr_ptr_q <= rr_ptr_d;
                        end else begin
                            result_q <= md_result_i;
                            state_q  <= RESP;
                        end
                    end else if (flush_i) begin
                        discard_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (flush_i || rsp_ready_i[owner_q]) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    mult_q     <= 1'b0;
                    div_q      <= 1'b0;
                    ready_id_q <= 1'b0;
                    discard_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_data_o       = (state_q == RESP) ? result_q : 32'd0;
    assign md_mult_en_o     = mult_q;
    assign md_mult_sel_o    = mult_q;
    assign md_div_en_o      = div_q;
    assign md_div_sel_o     = div_q;
    assign md_ready_id_o    = ready_id_q;
    assign md_operator_o    = operator_q;
    assign md_signed_mode_o = signed_q;
    assign md_op_a_o        = op_a_q;
    assign md_op_b_o        = op_b_q;

`ifdef IBEX_MDARB_PERF_EN
    logic [31:0] perf_busy_q;
    logic [31:0] perf_wait_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_busy_q <= '0;
            perf_wait_q <= '0;
        end else begin
            if ((state_q == BUSY) && (perf_busy_q != '1)) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if ((|req_valid_i) && !accept && (perf_wait_q != '1)) begin
                perf_wait_q <= perf_wait_q + 32'd1;
            end
        end
    end

    assign perf_busy_o = perf_busy_q;
    assign perf_wait_o = perf_wait_q;
`endif

endmodule

// File: tb/tb_ibex_multdiv_arbiter.sv
// Bench for ibex_multdiv_arbiter: directed and random ops served through a modelled iterative multdiv.
module tb_ibex_multdiv_arbiter;

    logic         clk_i;
    logic         rst_i;
    logic [1:0]   req_valid_i;
    logic [1:0]   req_ready_o;
    logic [3:0]   req_operator_i;
    logic [3:0]   req_signed_i;
    logic [63:0]  req_op_a_i;
    logic [63:0]  req_op_b_i;
    logic [1:0]   rsp_valid_o;
    logic [1:0]   rsp_ready_i;
    logic [31:0]  rsp_data_o;
    logic         flush_i;
    logic         md_mult_en_o;
    logic         md_div_en_o;
    logic         md_mult_sel_o;
    logic         md_div_sel_o;
    logic [1:0]   md_operator_o;
    logic [1:0]   md_signed_mode_o;
    logic [31:0]  md_op_a_o;
    logic [31:0]  md_op_b_o;
    logic         md_ready_id_o;
    logic         md_valid_i;
    logic [31:0]  md_result_i;
`ifdef IBEX_MDARB_PERF_EN
    logic [31:0]  perf_busy_o;
    logic [31:0]  perf_wait_o;
`endif

    ibex_multdiv_arbiter #(.NUM_REQ(2)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_operator_i   (req_operator_i),
        .req_signed_i     (req_signed_i),
        .req_op_a_i       (req_op_a_i),
        .req_op_b_i       (req_op_b_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_ready_i      (rsp_ready_i),
        .rsp_data_o       (rsp_data_o),
        .flush_i          (flush_i),
        .md_mult_en_o     (md_mult_en_o),
        .md_div_en_o      (md_div_en_o),
        .md_mult_sel_o    (md_mult_sel_o),
        .md_div_sel_o     (md_div_sel_o),
        .md_operator_o    (md_operator_o),
        .md_signed_mode_o (md_signed_mode_o),
        .md_op_a_o        (md_op_a_o),
        .md_op_b_o        (md_op_b_o),
        .md_ready_id_o    (md_ready_id_o),
        .md_valid_i       (md_valid_i),
        .md_result_i      (md_result_i)
`ifdef IBEX_MDARB_PERF_EN
        ,
        .perf_busy_o      (perf_busy_o),
        .perf_wait_o      (perf_wait_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          rr_ptr_m = 0;
    int          md_cnt = 0;
    int          md_lat = 1;
    logic [1:0]  r_op [2];
    logic [1:0]  r_sg [2];
    logic [31:0] r_a  [2];
    logic [31:0] r_b  [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Arithmetic the multdiv unit is expected to produce (RISC-V M semantics).
    function automatic logic [31:0] md_ref(input logic [1:0] op, input logic [1:0] sg,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, prod;
        logic        na, nb;
        logic [31:0] ma, mb, q, r;
        ea   = {{32{a[31] & sg[0]}}, a};
        eb   = {{32{b[31] & sg[1]}}, b};
        prod = ea * eb;
        if (op == 2'd0) return prod[31:0];
        if (op == 2'd1) return prod[63:32];
        if (b == 32'd0) return (op == 2'd2) ? 32'hFFFF_FFFF : a;
        na = a[31] & sg[0];
        nb = b[31] & sg[1];
        ma = na ? -a : a;
        mb = nb ? -b : b;
        q  = ma / mb;
        r  = ma % mb;
        if (op == 2'd2) return (na ^ nb) ? -q : q;
        return na ? -r : r;
    endfunction

    function automatic int exp_winner(input logic [1:0] vmask);
        for (int k = 0; k < 2; k++) begin
            if (vmask[(rr_ptr_m + k) % 2]) return (rr_ptr_m + k) % 2;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_reqs();
        for (int r = 0; r < 2; r++) begin
            req_operator_i[r*2 +: 2] = r_op[r];
            req_signed_i[r*2 +: 2]   = r_sg[r];
            req_op_a_i[r*32 +: 32]   = r_a[r];
            req_op_b_i[r*32 +: 32]   = r_b[r];
        end
    endtask

    // One clock, then the modelled multdiv reacts to its enables.
    task automatic tick();
        @(posedge clk_i);
        #1;
        if (md_valid_i) begin
            md_valid_i  = 1'b0;
            md_result_i = 32'd0;
            md_cnt      = 0;
        end else if (md_mult_en_o || md_div_en_o) begin
            md_cnt++;
            if (md_cnt >= md_lat) begin
                md_valid_i  = 1'b1;
                md_result_i = md_ref(md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o);
            end
        end
    endtask

    task automatic serve(input logic [1:0] vmask, input int lat, input int flush_at,
                         input bit flush_resp, input int rsp_delay);
        int          win, cyc;
        bit          got, had_v;
        logic [1:0]  op, sg, oh, exp_en;
        logic [31:0] a, b, expd;
        win = exp_winner(vmask);
        if (win < 0) return;
        op = r_op[win]; sg = r_sg[win]; a = r_a[win]; b = r_b[win];
        expd   = md_ref(op, sg, a, b);
        oh     = 2'(1 << win);
        exp_en = (op < 2'd2) ? 2'b10 : 2'b01;
        md_lat = lat;
        req_valid_i = vmask;
        #1;
        chk("accept_ready", 32'(req_ready_o), 32'(oh));
        chk("en_before_accept", 32'({md_mult_en_o, md_div_en_o}), 32'd0);
        tick();
        req_valid_i[win] = 1'b0;
        r_a[win] = $urandom; r_b[win] = $urandom; r_op[win] = 2'($urandom); r_sg[win] = 2'($urandom);
        drive_reqs();
        chk("en_after_accept", 32'({md_mult_en_o, md_div_en_o}), 32'(exp_en));
        chk("sel_after_accept", 32'({md_mult_sel_o, md_div_sel_o}), 32'(exp_en));
        chk("ready_id", 32'(md_ready_id_o), 32'd1);
        chk("md_operator", 32'(md_operator_o), 32'(op));
        chk("md_signed", 32'(md_signed_mode_o), 32'(sg));
        cyc = 0; got = 0;
        while (!got && cyc < 64) begin
            cyc++;
            if (cyc == flush_at) flush_i = 1'b1;
            #1;
            chk("busy_no_ready", 32'(req_ready_o), 32'd0);
            chk("busy_no_rsp", 32'(rsp_valid_o), 32'd0);
            chk("en_held", 32'({md_mult_en_o, md_div_en_o}), 32'(exp_en));
            chk("op_a_stable", md_op_a_o, a);
            chk("op_b_stable", md_op_b_o, b);
            had_v = md_valid_i;
            tick();
            flush_i = 1'b0;
            if (had_v) got = 1;
        end
        if (!got) chk("md_valid_timeout", 32'd0, 32'd1);
        chk("en_drop", 32'({md_mult_en_o, md_div_en_o, md_ready_id_o}), 32'd0);
        if (flush_at > 0 && flush_at <= cyc) begin
            chk("flush_no_rsp", 32'(rsp_valid_o), 32'd0);
            chk("flush_rsp_data", rsp_data_o, 32'd0);
            rr_ptr_m = (win + 1) % 2;
            $display("[TB] op req%0d op=%0d a=%08h b=%08h flushed", win, op, a, b);
            return;
        end
        chk("rsp_valid", 32'(rsp_valid_o), 32'(oh));
        chk("rsp_data", rsp_data_o, expd);
        for (int d = 0; d < rsp_delay; d++) begin
            rsp_ready_i = ~oh;
            #1;
            chk("hold_valid", 32'(rsp_valid_o), 32'(oh));
            chk("hold_data", rsp_data_o, expd);
            chk("hold_no_accept", 32'(req_ready_o), 32'd0);
            tick();
        end
        if (flush_resp) begin
            rsp_ready_i = 2'b00;
            flush_i     = 1'b1;
        end else begin
            rsp_ready_i = oh;
        end
        tick();
        flush_i     = 1'b0;
        rsp_ready_i = 2'b00;
        chk("rsp_drop", 32'(rsp_valid_o), 32'd0);
        chk("rsp_data_idle", rsp_data_o, 32'd0);
        rr_ptr_m = (win + 1) % 2;
        $display("[TB] op req%0d op=%0d sg=%0d a=%08h b=%08h exp=%08h%s", win, op, sg, a, b, expd,
                 flush_resp ? " (flushed in resp)" : "");
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, fa, rd;
        bit fr;
        logic [1:0] vm;
        rst_i = 1'b1; req_valid_i = 2'b01; rsp_ready_i = 2'b00; flush_i = 1'b0;
        md_valid_i = 1'b0; md_result_i = 32'd0;
        for (int r = 0; r < 2; r++) begin
            r_op[r] = 2'd0; r_sg[r] = 2'd0; r_a[r] = 32'd1; r_b[r] = 32'd1;
        end
        drive_reqs();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_req_ready", 32'(req_ready_o), 32'd0);
        chk("rst_rsp", {30'd0, rsp_valid_o} | rsp_data_o, 32'd0);
        chk("rst_md_ctrl", 32'({md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o, md_ready_id_o}), 32'd0);
        chk("rst_md_ops", md_op_a_o | md_op_b_o | 32'({md_operator_o, md_signed_mode_o}), 32'd0);
        req_valid_i = 2'b00;
        rst_i = 1'b0;
        tick();

        // Directed arithmetic cases
        r_op[0] = 2'd0; r_sg[0] = 2'b00; r_a[0] = 32'd7; r_b[0] = 32'd6; drive_reqs();
        serve(2'b01, 4, 0, 0, 0);
        r_op[1] = 2'd2; r_sg[1] = 2'b11; r_a[1] = -32'sd20; r_b[1] = 32'd3; drive_reqs();
        serve(2'b10, 6, 0, 0, 1);
        r_op[1] = 2'd3; r_sg[1] = 2'b11; r_a[1] = -32'sd20; r_b[1] = 32'd3; drive_reqs();
        serve(2'b10, 6, 0, 0, 0);
        r_op[0] = 2'd3; r_sg[0] = 2'b00; r_a[0] = 32'h1234; r_b[0] = 32'd0; drive_reqs();
        serve(2'b01, 5, 0, 0, 0);
        r_op[0] = 2'd2; r_sg[0] = 2'b00; r_a[0] = 32'h1234; r_b[0] = 32'd0; drive_reqs();
        serve(2'b01, 5, 0, 0, 0);

        // Round robin: bring rr_ptr to 0, then both requesting alternate 0,1,0
        r_op[1] = 2'd0; r_a[1] = 32'd2; r_b[1] = 32'd9; drive_reqs();
        serve(2'b10, 2, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            r_op[0] = 2'd1; r_sg[0] = 2'b11; r_a[0] = $urandom; r_b[0] = $urandom;
            r_op[1] = 2'd0; r_sg[1] = 2'b00; r_a[1] = $urandom; r_b[1] = $urandom;
            drive_reqs();
            serve(2'b11, 3, 0, 0, 0);
        end

        // Flush two cycles into req0 DIV while req1 MULL 3*5 waits
        r_op[1] = 2'd0; r_a[1] = 32'd1; r_b[1] = 32'd1; drive_reqs();
        serve(2'b10, 1, 0, 0, 0);
        r_op[0] = 2'd2; r_sg[0] = 2'b11; r_a[0] = 32'd100; r_b[0] = 32'd7;
        r_op[1] = 2'd0; r_sg[1] = 2'b00; r_a[1] = 32'd3;   r_b[1] = 32'd5;
        drive_reqs();
        serve(2'b11, 8, 2, 0, 0);
        serve(2'b10, 3, 0, 0, 0);

        // Response stalled five cycles with the other requester waiting
        r_op[0] = 2'd0; r_a[0] = 32'd11; r_b[0] = 32'd13; drive_reqs();
        serve(2'b11, 3, 0, 0, 5);
        serve(2'b10, 2, 0, 1, 2);

        // Flush while idle blocks the accept
        req_valid_i = 2'b01; flush_i = 1'b1;
        #1;
        chk("idle_flush_blocks", 32'(req_ready_o), 32'd0);
        tick();
        flush_i = 1'b0;
        chk("idle_flush_no_busy", 32'({md_ready_id_o, md_mult_en_o, md_div_en_o}), 32'd0);
        req_valid_i = 2'b00;

        // Reset in the middle of an operation
        r_op[0] = 2'd0; r_a[0] = 32'd5; r_b[0] = 32'd5; drive_reqs();
        req_valid_i = 2'b01;
        tick();
        req_valid_i = 2'b00;
        tick();
        rst_i = 1'b1;
        #1;
        chk("midop_rst_ctrl", 32'({md_mult_en_o, md_div_en_o, md_ready_id_o}), 32'd0);
        chk("midop_rst_ops", md_op_a_o | md_op_b_o, 32'd0);
        chk("midop_rst_rsp", 32'(rsp_valid_o), 32'd0);
        md_valid_i = 1'b0; md_result_i = 32'd0; md_cnt = 0; rr_ptr_m = 0;
        tick();
        rst_i = 1'b0;
        tick();

        // Random traffic
        for (int it = 0; it < 40; it++) begin
            vm = 2'($urandom_range(1, 3));
            for (int r = 0; r < 2; r++) begin
                r_op[r] = 2'($urandom_range(0, 3));
                r_sg[r] = 2'($urandom_range(0, 3));
                r_a[r]  = rnd_word();
                r_b[r]  = rnd_word();
            end
            drive_reqs();
            lat = $urandom_range(1, 8);
            fa  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, lat)) : 0;
            fr  = ($urandom_range(0, 7) == 0);
            rd  = $urandom_range(0, 3);
            serve(vm, lat, fa, fr, rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
